// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet hit scanner: colour codes, field slices, FSM states.
package bullet_pkg;

    // Bullet colour codes as stored in the bullet table
    localparam logic [1:0] WHITE = 2'b00;
    localparam logic [1:0] GREEN = 2'b01;
    localparam logic [1:0] BLUE  = 2'b10;

    // Packed {x, y} position and {w, h} size field slices
    localparam int unsigned X_MSB = 15;
    localparam int unsigned X_LSB = 8;
    localparam int unsigned Y_MSB = 7;
    localparam int unsigned Y_LSB = 0;
    localparam int unsigned W_MSB = 15;
    localparam int unsigned W_LSB = 8;
    localparam int unsigned H_MSB = 7;
    localparam int unsigned H_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        EVAL,
        HIT,
        RELEASE,
        DEAD
    } state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap; edge-touching boxes do not overlap.
module aabb_overlap
    import bullet_pkg::*;
(
    input  logic [15:0] i_a_pos,
    input  logic [15:0] i_a_size,
    input  logic [15:0] i_b_pos,
    input  logic [15:0] i_b_size,
    output logic        o_overlap
);

    // 9-bit coordinates so that x+w never wraps past 255
    logic [8:0] w_ax, w_ay, w_bx, w_by;
    logic [8:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

    // Far edges of both boxes and the four strict interval tests
    always_comb begin
        w_ax      = {1'b0, i_a_pos[X_MSB:X_LSB]};
        w_ay      = {1'b0, i_a_pos[Y_MSB:Y_LSB]};
        w_bx      = {1'b0, i_b_pos[X_MSB:X_LSB]};
        w_by      = {1'b0, i_b_pos[Y_MSB:Y_LSB]};
        w_ax_end  = w_ax + {1'b0, i_a_size[W_MSB:W_LSB]};
        w_ay_end  = w_ay + {1'b0, i_a_size[H_MSB:H_LSB]};
        w_bx_end  = w_bx + {1'b0, i_b_size[W_MSB:W_LSB]};
        w_by_end  = w_by + {1'b0, i_b_size[H_MSB:H_LSB]};
        o_overlap = (w_bx < w_ax_end) && (w_ax < w_bx_end) &&
                    (w_by < w_ay_end) && (w_ay < w_by_end);
    end

endmodule

// File: rtl/bullet_hit_scanner.sv
// Walks the bullet table, tests each live slot against the player hitbox and tracks HP.
module bullet_hit_scanner
    import bullet_pkg::*;
#(
    parameter int unsigned NUM_BULLETS   = 3,
    parameter int unsigned HP_MAX        = 20,
    parameter int unsigned DAMAGE        = 1,
    parameter int unsigned HEAL          = 1,
    parameter int unsigned INVULN_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isRun,
    input  logic [15:0] player_position,
    input  logic [15:0] player_size,
    input  logic        player_moving,
    output logic [2:0]  index,
    input  logic [15:0] bullet_position,
    input  logic [15:0] bullet_size,
    input  logic [1:0]  bullet_color,
    input  logic        bullet_render,
    output logic        isCollide,
    output logic [7:0]  hp,
    output logic        dead
);

    localparam int unsigned COOL_W = $clog2(INVULN_CYCLES + 1);

    state_t            r_state, w_state;
    logic [2:0]        r_index, w_index;
    logic              r_collide, w_collide;
    logic [7:0]        r_hp, w_hp;
    logic              r_dead, w_dead;
    logic [COOL_W-1:0] r_cool, w_cool;
    logic              r_heal, w_heal;

    logic       w_overlap;
    logic       w_color_ok;
    logic       w_qual;
    logic [2:0] w_next_index;
    logic [8:0] w_heal_sum;
    logic [7:0] w_hp_heal;
    logic [7:0] w_hp_dmg;

    aabb_overlap u_aabb (
        .i_a_pos   (player_position),
        .i_a_size  (player_size),
        .i_b_pos   (bullet_position),
        .i_b_size  (bullet_size),
        .o_overlap (w_overlap)
    );

    // Hit qualification, wrapped index and saturated HP candidates
    always_comb begin
        case (bullet_color)
            WHITE:   w_color_ok = (r_cool == '0);
            BLUE:    w_color_ok = player_moving && (r_cool == '0);
            GREEN:   w_color_ok = 1'b1;
            default: w_color_ok = 1'b0;
        endcase
        w_qual       = bullet_render && w_overlap && w_color_ok;
        w_next_index = (r_index == 3'(NUM_BULLETS - 1)) ? 3'd0 : r_index + 3'd1;
        w_heal_sum   = {1'b0, r_hp} + 9'(HEAL);
        w_hp_heal    = (w_heal_sum > 9'(HP_MAX)) ? 8'(HP_MAX) : w_heal_sum[7:0];
        w_hp_dmg     = (r_hp > 8'(DAMAGE)) ? (r_hp - 8'(DAMAGE)) : 8'd0;
    end

    // Next-state logic; isRun low overrides everything and restarts the game state
    always_comb begin
        w_state   = r_state;
        w_index   = r_index;
        w_collide = 1'b0;
        w_hp      = r_hp;
        w_dead    = r_dead;
        w_heal    = r_heal;
        w_cool    = ((r_state != IDLE) && (r_cool != '0)) ? (r_cool - COOL_W'(1)) : r_cool;

        case (r_state)
            IDLE: begin
                w_index = 3'd0;
                w_state = ADDR;
            end
            ADDR: w_state = EVAL;
            EVAL: begin
                if (w_qual) begin
                    w_state   = HIT;
                    w_collide = 1'b1;
                    // Colour is latched so HIT does not depend on the table after the pulse
                    w_heal    = (bullet_color == GREEN);
                end else begin
                    w_index = w_next_index;
                    w_state = ADDR;
                end
            end
            HIT: begin
                if (r_heal) begin
                    w_hp = w_hp_heal;
                end else begin
                    w_hp   = w_hp_dmg;
                    w_cool = COOL_W'(INVULN_CYCLES);
                end
                w_state = RELEASE;
            end
            RELEASE: begin
                if (r_hp == 8'd0) begin
                    w_state = DEAD;
                    w_dead  = 1'b1;
                end else begin
                    w_index = w_next_index;
                    w_state = ADDR;
                end
            end
            DEAD:    w_dead = 1'b1;
            default: w_state = IDLE;
        endcase

        if (!isRun) begin
            w_state   = IDLE;
            w_index   = 3'd0;
            w_collide = 1'b0;
            w_hp      = 8'(HP_MAX);
            w_dead    = 1'b0;
            w_cool    = '0;
            w_heal    = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_index   <= 3'd0;
            r_collide <= 1'b0;
            r_hp      <= 8'(HP_MAX);
            r_dead    <= 1'b0;
            r_cool    <= '0;
            r_heal    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_index   <= w_index;
            r_collide <= w_collide;
            r_hp      <= w_hp;
            r_dead    <= w_dead;
            r_cool    <= w_cool;
            r_heal    <= w_heal;
        end
    end

    assign index     = r_index;
    assign isCollide = r_collide;
    assign hp        = r_hp;
    assign dead      = r_dead;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Scoreboard bench: stimulus pushes expected hits, a monitor checks every isCollide pulse.
module tb_bullet_hit_scanner;
    import bullet_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        isRun;
    logic [15:0] player_position;
    logic [15:0] player_size;
    logic        player_moving;
    logic [2:0]  index;
    logic [15:0] bullet_position;
    logic [15:0] bullet_size;
    logic [1:0]  bullet_color;
    logic        bullet_render;
    logic        isCollide;
    logic [7:0]  hp;
    logic        dead;

    always #5 clk = ~clk;

    bullet_hit_scanner dut (
        .clk             (clk),
        .reset           (reset),
        .isRun           (isRun),
        .player_position (player_position),
        .player_size     (player_size),
        .player_moving   (player_moving),
        .index           (index),
        .bullet_position (bullet_position),
        .bullet_size     (bullet_size),
        .bullet_color    (bullet_color),
        .bullet_render   (bullet_render),
        .isCollide       (isCollide),
        .hp              (hp),
        .dead            (dead)
    );

    // Bullet table model; a slot is live while armed and not yet cleared by a hit
    logic [7:0] tb_x [8];
    logic [7:0] tb_y [8];
    logic [7:0] tb_w [8];
    logic [7:0] tb_h [8];
    logic [1:0] tb_col [8];
    logic       tb_render [8];
    int         gen [8];
    int         clr_gen [8];

    always @(posedge clk) begin
        if (isCollide === 1'b1) clr_gen[index] <= gen[index];
    end

    assign bullet_position = {tb_x[index], tb_y[index]};
    assign bullet_size     = {tb_w[index], tb_h[index]};
    assign bullet_color    = tb_col[index];
    assign bullet_render   = tb_render[index] && (clr_gen[index] != gen[index]);

    typedef struct {
        int idx;
        int hp;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_hp;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic arm(input int s, input logic [7:0] x, input logic [7:0] w,
                       input logic [1:0] col);
        tb_x[s]      = x;
        tb_y[s]      = 8'd19;
        tb_w[s]      = w;
        tb_h[s]      = 8'd16;
        tb_col[s]    = col;
        tb_render[s] = 1'b1;
        gen[s]       = gen[s] + 1;
    endtask

    task automatic expect_hit(input int idx, input int new_hp);
        exp_t e;
        e.idx = idx;
        e.hp  = new_hp;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_empty(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    // Monitor: every pulse must match the head of the queue and last exactly one cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (isCollide === 1'b1) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: got pulse at index %0d, expected none",
                             index);
                    @(negedge clk);
                end else begin
                    e = q.pop_front();
                    chk("pulse_index", int'(index), e.idx);
                    @(negedge clk);
                    chk("pulse_width", int'(isCollide), 0);
                    chk("index_after_pulse", int'(index), e.idx);
                    chk("hp_after_hit", int'(hp), e.hp);
                end
            end
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) begin
            tb_x[i] = '0; tb_y[i] = '0; tb_w[i] = '0; tb_h[i] = '0;
            tb_col[i] = WHITE; tb_render[i] = 1'b0;
        end
        reset           = 1'b1;
        isRun           = 1'b0;
        player_moving   = 1'b0;
        player_position = {8'd150, 8'd15};
        player_size     = {8'd16, 8'd16};
        wait_cyc(3);
        chk("reset_index", int'(index), 0);
        chk("reset_collide", int'(isCollide), 0);
        chk("reset_hp", int'(hp), 20);
        chk("reset_dead", int'(dead), 0);
        reset = 1'b0;
        wait_cyc(1);
        isRun = 1'b1;

        // White overlap, then a second overlap inside the invulnerability window
        arm(0, 8'd160, 8'd16, WHITE);
        exp_hp = 19;
        expect_hit(0, exp_hp);
        wait_cyc(20);
        chk_empty("white_hit");
        arm(1, 8'd160, 8'd16, WHITE);
        wait_cyc(20);
        chk("cooldown_hp", int'(hp), 19);
        tb_render[1] = 1'b0;
        wait_cyc(70);

        // Miss and edge-touch, then one pixel of overlap
        arm(0, 8'd100, 8'd16, WHITE);
        arm(1, 8'd134, 8'd16, WHITE);
        wait_cyc(20);
        chk("edge_miss_hp", int'(hp), 19);
        tb_render[0] = 1'b0;
        tb_render[1] = 1'b0;
        arm(2, 8'd135, 8'd16, WHITE);
        exp_hp = 18;
        expect_hit(2, exp_hp);
        wait_cyc(20);
        chk_empty("edge_hit");

        // Green heals and saturates at HP_MAX, ignoring cooldown
        arm(0, 8'd160, 8'd16, GREEN);
        expect_hit(0, 19);
        wait_cyc(20);
        arm(0, 8'd160, 8'd16, GREEN);
        expect_hit(0, 20);
        wait_cyc(20);
        arm(0, 8'd160, 8'd16, GREEN);
        exp_hp = 20;
        expect_hit(0, exp_hp);
        wait_cyc(20);
        chk_empty("green_sat");

        // Blue only hurts a moving player
        wait_cyc(70);
        arm(1, 8'd160, 8'd16, BLUE);
        wait_cyc(20);
        chk("blue_still_hp", int'(hp), 20);
        player_moving = 1'b1;
        exp_hp = 19;
        expect_hit(1, exp_hp);
        wait_cyc(20);
        chk_empty("blue_moving");
        player_moving = 1'b0;

        // Drain HP to zero; dead blocks further pulses
        while (exp_hp > 0) begin
            wait_cyc(70);
            arm(0, 8'd160, 8'd16, WHITE);
            exp_hp--;
            expect_hit(0, exp_hp);
            wait_cyc(20);
            chk_empty("drain_hit");
        end
        chk("dead_set", int'(dead), 1);
        arm(1, 8'd160, 8'd16, GREEN);
        wait_cyc(20);
        chk("dead_hp", int'(hp), 0);
        chk("dead_hold", int'(dead), 1);
        tb_render[1] = 1'b0;
        isRun = 1'b0;
        wait_cyc(1);
        isRun = 1'b1;
        chk("restart_hp", int'(hp), 20);
        chk("restart_dead", int'(dead), 0);
        chk("restart_index", int'(index), 0);
        wait_cyc(2);
        chk("rerun_dead", int'(dead), 0);

        // 9-bit sums: 250+16 = 266 must not wrap
        player_position = {8'd250, 8'd15};
        arm(0, 8'd255, 8'd1, WHITE);
        expect_hit(0, 19);
        wait_cyc(20);
        chk_empty("wrap_hit");
        wait_cyc(70);

        // Drop isRun during HIT: pulse truncated, HP reloaded, damage discarded
        arm(0, 8'd255, 8'd1, WHITE);
        expect_hit(0, 20);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (isCollide === 1'b1) begin
                seen  = 1'b1;
                isRun = 1'b0;
            end
        end
        n_total++;
        if (seen) n_pass++;
        else $display("FAIL abort_pulse: got no pulse within 40 cycles, expected one");
        @(negedge clk);
        isRun = 1'b1;
        wait_cyc(20);
        chk_empty("abort");
        chk("abort_hp", int'(hp), 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bullet_hit_scanner.md
# bullet_hit_scanner

Reader side of the bullet table's index/collision port. It walks the bullet table one index at a time and reads each slot's position, size, colour and render flag. Each slot is tested against the player hitbox. On a qualifying hit, the block pulses `isCollide` so the table clears that slot's render bit, and it updates the player's HP. It sits between the bullet table and the HUD/game-over logic; the VGA side keeps its own index port.

## Interface
Parameters:
- `NUM_BULLETS`, 3: number of table slots scanned, indices 0..NUM_BULLETS-1.
- `HP_MAX`, 20: HP after reset or after `isRun` drops.
- `DAMAGE`, 1: HP removed per damaging hit.
- `HEAL`, 1: HP added per green hit.
- `INVULN_CYCLES`, 64: cycles after a damaging hit during which damage hits are ignored.

Ports:
- `clk` in 1: the single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `isRun` in 1: scanning enable. Low means restart the game state.
- `player_position` in 16: {x[15:8], y[7:0]}.
- `player_size` in 16: {w[15:8], h[7:0]}.
- `player_moving` in 1: player moved this frame.
- `index` out 3: slot select, driven to the table's collision index input.
- `bullet_position` in 16: {x, y} of the selected slot, combinational from the table.
- `bullet_size` in 16: {w, h} of the selected slot.
- `bullet_color` in 2: 00 white, 01 green, 10 blue, 11 ignored.
- `bullet_render` in 1: slot is live.
- `isCollide` out 1: one-cycle hit pulse for slot `index`.
- `hp` out 8: current HP, saturating.
- `dead` out 1: HP reached 0.

## Operation
- FSM states: IDLE, ADDR, EVAL, HIT, RELEASE, DEAD.
- IDLE → ADDR when `isRun`=1; `index`=0.
- ADDR: `index` is stable and table outputs settle. Go to EVAL.
- EVAL: compute `qual` = `bullet_render` & overlap & colour rule.
  - If `qual`, go to HIT.
  - Otherwise advance `index` (wrap NUM_BULLETS-1 → 0) and go to ADDR.
- Colour rule:
  - White: qualifies when cooldown = 0.
  - Blue: qualifies when `player_moving` & cooldown = 0.
  - Green: always qualifies.
  - 11: never qualifies.
- HIT: `isCollide`=1 for this cycle only.
  - White/blue: `hp` = max(hp−DAMAGE, 0) and cooldown loaded with INVULN_CYCLES.
  - Green: `hp` = min(hp+HEAL, HP_MAX); cooldown untouched.
  - Go to RELEASE.
- RELEASE: `isCollide`=0 with `index` unchanged. Then advance `index` and go to ADDR, or go to DEAD if `hp`=0.
- DEAD: `dead`=1 and no further pulses; stays until `isRun`=0 or `reset`.
- Cooldown counter decrements every cycle while nonzero, in every state except IDLE.
- Overlap test: strict AABB, all sums 9-bit unsigned, no wrap.
  - Condition: bx < px+pw, px < bx+bw, by < py+ph and py < by+bh.
  - Edge-touching rectangles do not overlap.
- `isRun`=0 in any state: next cycle state=IDLE, `index`=0, `isCollide`=0, `hp`=HP_MAX, `dead`=0, cooldown=0.

## Timing
- Reset values: state IDLE, `index`=0, `isCollide`=0, `hp`=HP_MAX, `dead`=0, cooldown 0.
- `reset` has priority over `isRun`.
- All outputs are registered.
- No-hit slot: 2 cycles (ADDR, EVAL). Full no-hit sweep of 3 slots: 6 cycles.
- Hit slot: 4 cycles (ADDR, EVAL, HIT, RELEASE).
- `index` is held constant from the ADDR cycle through RELEASE. It is therefore stable one cycle before the rising edge of `isCollide` and one cycle after it falls.
- `hp` and `dead` update on the clock edge that ends HIT and RELEASE respectively.
- A bullet moving on the same edge as EVAL is evaluated at its new position.
- `isRun` falling during HIT truncates the pulse; `hp` is reloaded and the HIT update is discarded.

## Structure
- Shared package `bullet_pkg` holds:
  - Colour codes: WHITE=2'b00, GREEN=2'b01, BLUE=2'b10.
  - Field slice constants for position/size packing.
  - The FSM state enum.
- One combinational sub-module, `aabb_overlap`: two {x,y,w,h} boxes in, 1-bit overlap out, 9-bit internal sums.

## Test plan
Every scenario uses player {x=150, y=15, w=16, h=16}.
- **White overlap:** bullet {160, 19, 16, 16}, white, render=1. `isCollide` pulses 1 cycle; `hp` 20→19; a second overlap within 64 cycles gives no pulse.
- **Miss / edge-touch:** bullet x=100 w=16, no pulse. Bullet x=134 w=16 (right edge = 150), no pulse. Bullet x=135, pulse.
- **Green saturation:** green overlap at hp=19 gives hp=20; at hp=20 it stays 20; a pulse fires both times.
- **Blue rule:** blue overlap with `player_moving`=0 gives no pulse and hp unchanged; with `player_moving`=1 it gives a pulse and hp−1.
- **Death:** at hp=1, a white hit gives hp=0, `dead`=1 the next cycle, and no further pulses. `isRun` 1→0→1 gives hp=20 and `dead`=0.
- **Wrap / abort:** player x=250 w=16 with bullet x=255 w=1 gives overlap (9-bit). Dropping `isRun` during HIT gives `isCollide`=0 the next cycle and `index`=0.
